execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Y86-64 pipeline execute stage with the M (memory) pipeline register.
- Consumes the E-register outputs: ALU operand selection, ALU, condition-code register (CC) and branch/cmov condition evaluation.
- Drives combinational forwarding signals to decode and hazard control, and registers results into M on each rising clk.

Parameters:
- WORD, 64, datapath width of valA/valB/valC/valE.
- RNONE, 4'hF, register ID meaning "no register".

Ports:
- clk  in  1  Single system clock; all state updates on rising edge.
- reset  in  1  Synchronous, active-high reset.
- E_icode  in  4  Instruction code from the E register.
- E_ifun  in  4  Function code from the E register.
- E_valA  in  WORD  Operand A.
- E_valB  in  WORD  Operand B.
- E_valC  in  WORD  Constant.
- E_dstE  in  4  Destination for valE.
- E_dstM  in  4  Destination for the memory read.
- cc_inhibit  in  1  From control; 1 blocks the CC update (exception in M or W).
- M_bubble  in  1  From control; loads a nop into M.
- e_valE  out  WORD  Combinational ALU result (forwarding).
- e_dstE  out  4  Combinational effective dstE (forwarding).
- e_Cnd  out  1  Combinational condition result.
- M_icode  out  4  Registered.
- M_Cnd  out  1  Registered.
- M_valE  out  WORD  Registered.
- M_valA  out  WORD  Registered.
- M_dstE  out  4  Registered.
- M_dstM  out  4  Registered.
- cc_out  out  3  {ZF,SF,OF}; current CC register.

Behaviour:
Opcode values:
- 0 halt, 1 nop, 2 cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
- Any other icode: aluA=0, aluB=0, no CC update.

ALU operand selection:
- aluA: E_valA for icode 2 and 6; E_valC for 3, 4, 5; -8 for 8 and A; +8 for 9 and B; 0 otherwise.
- aluB: E_valB for 4, 5, 6, 8, 9, A, B; 0 for 2 and 3.

ALU function and result:
- Function is E_ifun only when icode=6; otherwise it is add.
- Functions: 0 add (B+A), 1 sub (B−A), 2 and, 3 xor; other ifun values with icode 6 give add.
- Result is WORD bits, wrap-around modulo 2^WORD, no carry output.

Flags:
- ZF = (result==0); SF = result[WORD-1].
- OF for add: (A<0)==(B<0) && (res<0)!=(A<0).
- OF for sub: (A<0)!=(B<0) && (res<0)!=(B<0).
- OF for and/xor: 0.

CC register:
- Updates at posedge iff E_icode==6 && !cc_inhibit && !reset.
- Otherwise it holds its value. An M_bubble does not block the CC update.

Condition e_Cnd (from the current CC, not the value being written this cycle):
- ifun 0: 1
- ifun 1: (SF^OF)|ZF
- ifun 2: SF^OF
- ifun 3: ZF
- ifun 4: !ZF
- ifun 5: !(SF^OF)
- ifun 6: !(SF^OF)&!ZF
- other: 0

Effective destination:
- e_dstE = RNONE when E_icode==2 && !e_Cnd; otherwise E_dstE.
- e_valE = ALU result.
- All combinational outputs have zero latency from the E inputs.

M register, at posedge, by priority:
- reset: M_icode=1, M_Cnd=0, M_valE=0, M_valA=0, M_dstE=RNONE, M_dstM=RNONE; CC={ZF=1,SF=0,OF=0}.
- else M_bubble: same nop values as reset; CC still follows its own update rule.
- else: M_icode←E_icode, M_Cnd←e_Cnd, M_valE←e_valE, M_valA←E_valA, M_dstE←e_dstE, M_dstM←E_dstM.

Latency:
- 1 cycle from E inputs to M outputs.
- A jXX or cmov placed directly after an OPq sees the CC written by that OPq (its update is visible one cycle later).

Reset mid-operation:
- The in-flight instruction is discarded and M becomes a nop.
- After reset deasserts, the first E input is captured on the next edge.

Test Plan:
- Reset high for 1 edge with arbitrary E inputs -> M_icode=1, M_dstE=M_dstM=F, M_valE=0, cc_out=3'b100.
- OPq add (icode 6, ifun 0), valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> e_valE=0x8000_0000_0000_0000; next cycle cc_out=ZF0,SF1,OF1 and M_valE matches.
- OPq sub, valA=5, valB=5 -> e_valE=0, CC ZF=1; then cmovle (2,1) rA→dstE=3 -> e_Cnd=1, M_dstE=3. Repeat after sub valA=3, valB=5 (CC 000) -> e_Cnd=0, M_dstE=F.
- OPq with cc_inhibit=1 -> cc_out unchanged; M still captures e_valE.
- pushq with valB=0x100 -> e_valE=0xF8; popq with valB=0x100 -> e_valE=0x108; call with valB=0 -> e_valE=0xFFFF_FFFF_FFFF_FFF8 (wrap).
- M_bubble=1 during an OPq -> M outputs take nop values while CC still updates; jne (7,4) in the following cycle -> e_Cnd reflects the new CC.

Source files
------------

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand selection, ALU, condition codes and the
// branch/cmov condition, registering the results into the M pipeline register.
module execute_stage #(
  parameter int         WORD  = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      E_icode,
  input  logic [3:0]      E_ifun,
  input  logic [WORD-1:0] E_valA,
  input  logic [WORD-1:0] E_valB,
  input  logic [WORD-1:0] E_valC,
  input  logic [3:0]      E_dstE,
  input  logic [3:0]      E_dstM,
  input  logic            cc_inhibit,
  input  logic            M_bubble,
  output logic [WORD-1:0] e_valE,
  output logic [3:0]      e_dstE,
  output logic            e_Cnd,
  output logic [3:0]      M_icode,
  output logic            M_Cnd,
  output logic [WORD-1:0] M_valE,
  output logic [WORD-1:0] M_valA,
  output logic [3:0]      M_dstE,
  output logic [3:0]      M_dstM,
  output logic [2:0]      cc_out
);

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] ICMOVXX = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] ALUADD = 4'h0;
  localparam logic [3:0] ALUSUB = 4'h1;
  localparam logic [3:0] ALUAND = 4'h2;
  localparam logic [3:0] ALUXOR = 4'h3;

  localparam logic [WORD-1:0] POS8 = WORD'(8);
  localparam logic [WORD-1:0] NEG8 = ~(WORD'(7));
  localparam logic [WORD-1:0] ZERO = '0;

  localparam logic [2:0] CCRESET = 3'b100;

  logic [WORD-1:0] aluA;
  logic [WORD-1:0] aluB;
  logic [3:0]      aluFun;
  logic [WORD-1:0] aluRes;
  logic            newZf;
  logic            newSf;
  logic            newOf;
  logic            aNeg;
  logic            bNeg;
  logic            rNeg;
  logic [2:0]      ccReg;
  logic            zf;
  logic            sf;
  logic            of;
  logic            setCc;

  // Operand A selection
  always_comb begin
    aluA = ZERO;
    case (E_icode)
      ICMOVXX, IOPQ:             aluA = E_valA;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: aluA = E_valC;
      ICALL, IPUSHQ:             aluA = NEG8;
      IRET, IPOPQ:               aluA = POS8;
      default:                   aluA = ZERO;
    endcase
  end

  // Operand B selection
  always_comb begin
    aluB = ZERO;
    case (E_icode)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: aluB = E_valB;
      default:                                           aluB = ZERO;
    endcase
  end

  assign aluFun = (E_icode == IOPQ) ? E_ifun : ALUADD;

  // Unknown OPq function codes fall back to add.
  always_comb begin
    aluRes = aluB + aluA;
    case (aluFun)
      ALUSUB:  aluRes = aluB - aluA;
      ALUAND:  aluRes = aluB & aluA;
      ALUXOR:  aluRes = aluB ^ aluA;
      default: aluRes = aluB + aluA;
    endcase
  end

  assign aNeg  = aluA[WORD-1];
  assign bNeg  = aluB[WORD-1];
  assign rNeg  = aluRes[WORD-1];
  assign newZf = (aluRes == ZERO);
  assign newSf = rNeg;

  always_comb begin
    newOf = 1'b0;
    case (aluFun)
      ALUSUB:         newOf = (aNeg != bNeg) && (rNeg != bNeg);
      ALUAND, ALUXOR: newOf = 1'b0;
      default:        newOf = (aNeg == bNeg) && (rNeg != aNeg);
    endcase
  end

  assign setCc = (E_icode == IOPQ) && !cc_inhibit;

  always_ff @(posedge clk) begin
    if (reset) begin
      ccReg <= CCRESET;
    end else if (setCc) begin
      ccReg <= {newZf, newSf, newOf};
    end
  end

  assign zf     = ccReg[2];
  assign sf     = ccReg[1];
  assign of     = ccReg[0];
  assign cc_out = ccReg;

  // Condition is evaluated from the committed CC, never from this cycle's flags.
  always_comb begin
    e_Cnd = 1'b0;
    case (E_ifun)
      4'h0:    e_Cnd = 1'b1;
      4'h1:    e_Cnd = (sf ^ of) | zf;
      4'h2:    e_Cnd = sf ^ of;
      4'h3:    e_Cnd = zf;
      4'h4:    e_Cnd = !zf;
      4'h5:    e_Cnd = !(sf ^ of);
      4'h6:    e_Cnd = !(sf ^ of) && !zf;
      default: e_Cnd = 1'b0;
    endcase
  end

  assign e_valE = aluRes;
  assign e_dstE = ((E_icode == ICMOVXX) && !e_Cnd) ? RNONE : E_dstE;

  always_ff @(posedge clk) begin
    if (reset || M_bubble) begin
      M_icode <= INOP;
      M_Cnd   <= 1'b0;
      M_valE  <= ZERO;
      M_valA  <= ZERO;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

  // Halt is carried through unchanged; it only matters to later stages.
  logic unusedHalt;
  assign unusedHalt = (E_icode == IHALT) && (E_icode == IJXX);

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: hand-computed vectors checked with
// immediate assertions on combinational and registered outputs.
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [63:0] E_valC;
  logic [3:0]  E_dstE;
  logic [3:0]  E_dstM;
  logic        cc_inhibit;
  logic        M_bubble;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [2:0]  cc_out;

  int checks = 0;
  int failures = 0;

  execute_stage #(.WORD(64), .RNONE(4'hF)) dut (
    .clk(clk), .reset(reset),
    .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .cc_inhibit(cc_inhibit), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .cc_out(cc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply E inputs just after a falling edge, then settle combinational logic.
  task automatic setE(input logic [3:0] icode, input logic [3:0] ifun,
                      input logic [63:0] valA, input logic [63:0] valB,
                      input logic [63:0] valC, input logic [3:0] dstE,
                      input logic [3:0] dstM);
    @(negedge clk);
    E_icode = icode;
    E_ifun  = ifun;
    E_valA  = valA;
    E_valB  = valB;
    E_valC  = valC;
    E_dstE  = dstE;
    E_dstM  = dstM;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cc_inhibit = 1'b0;
    M_bubble = 1'b0;

    // Reset with an OPq on the inputs: CC must not take its flags.
    setE(4'h6, 4'h1, 64'h1234, 64'h0, 64'h55, 4'h2, 4'h3);
    tick();
    check("rst_M_icode", 64'(M_icode), 64'h1);
    check("rst_M_Cnd", 64'(M_Cnd), 64'h0);
    check("rst_M_valE", M_valE, 64'h0);
    check("rst_M_valA", M_valA, 64'h0);
    check("rst_M_dstE", 64'(M_dstE), 64'hF);
    check("rst_M_dstM", 64'(M_dstM), 64'hF);
    check("rst_cc", 64'(cc_out), 64'h4);

    reset = 1'b0;

    // add overflow
    setE(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h2, 4'hF);
    check("add_e_valE", e_valE, 64'h8000_0000_0000_0000);
    check("add_e_dstE", 64'(e_dstE), 64'h2);
    tick();
    check("add_cc", 64'(cc_out), 64'h3);
    check("add_M_valE", M_valE, 64'h8000_0000_0000_0000);
    check("add_M_valA", M_valA, 64'h7FFF_FFFF_FFFF_FFFF);
    check("add_M_icode", 64'(M_icode), 64'h6);
    check("add_M_dstE", 64'(M_dstE), 64'h2);
    check("add_M_Cnd", 64'(M_Cnd), 64'h1);

    // sub equal -> ZF
    setE(4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h1, 4'hF);
    check("subeq_e_valE", e_valE, 64'h0);
    tick();
    check("subeq_cc", 64'(cc_out), 64'h4);

    // cmovle taken
    setE(4'h2, 4'h1, 64'h55, 64'h99, 64'h0, 4'h3, 4'hF);
    check("cmovle_t_Cnd", 64'(e_Cnd), 64'h1);
    check("cmovle_t_e_dstE", 64'(e_dstE), 64'h3);
    check("cmovle_t_e_valE", e_valE, 64'h55);
    tick();
    check("cmovle_t_M_dstE", 64'(M_dstE), 64'h3);
    check("cmovle_t_M_Cnd", 64'(M_Cnd), 64'h1);
    check("cmovle_t_M_valE", M_valE, 64'h55);

    // sub 5-3 -> CC 000
    setE(4'h6, 4'h1, 64'h3, 64'h5, 64'h0, 4'h1, 4'hF);
    check("sub_e_valE", e_valE, 64'h2);
    tick();
    check("sub_cc", 64'(cc_out), 64'h0);

    // cmovle not taken
    setE(4'h2, 4'h1, 64'h55, 64'h99, 64'h0, 4'h3, 4'hF);
    check("cmovle_n_Cnd", 64'(e_Cnd), 64'h0);
    check("cmovle_n_e_dstE", 64'(e_dstE), 64'hF);
    tick();
    check("cmovle_n_M_dstE", 64'(M_dstE), 64'hF);
    check("cmovle_n_M_Cnd", 64'(M_Cnd), 64'h0);

    // inhibited OPq (and, result 0 would set ZF)
    cc_inhibit = 1'b1;
    setE(4'h6, 4'h2, 64'hFF00, 64'h00FF, 64'h0, 4'h4, 4'hF);
    check("inh_e_valE", e_valE, 64'h0);
    tick();
    check("inh_cc", 64'(cc_out), 64'h0);
    check("inh_M_valE", M_valE, 64'h0);
    check("inh_M_dstE", 64'(M_dstE), 64'h4);
    cc_inhibit = 1'b0;

    // and / xor / unknown-ifun add results
    setE(4'h6, 4'h2, 64'hFF00, 64'h0FF0, 64'h0, 4'h4, 4'hF);
    check("and_e_valE", e_valE, 64'h0F00);
    setE(4'h6, 4'h3, 64'hFF00, 64'h0FF0, 64'h0, 4'h4, 4'hF);
    check("xor_e_valE", e_valE, 64'hF0F0);
    setE(4'h6, 4'h5, 64'h2, 64'h3, 64'h0, 4'h4, 4'hF);
    check("opq_ifun5_e_valE", e_valE, 64'h5);
    tick();
    check("opq_ifun5_cc", 64'(cc_out), 64'h0);

    // jXX sweep with CC = 000
    setE(4'h7, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    check("jmp_cc000", 64'(e_Cnd), 64'h1);
    setE(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    check("jle_cc000", 64'(e_Cnd), 64'h0);
    setE(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    check("jl_cc000", 64'(e_Cnd), 64'h0);
    setE(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    check("je_cc000", 64'(e_Cnd), 64'h0);
    setE(4'h7, 4'h4, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    check("jne_cc000", 64'(e_Cnd), 64'h1);
    setE(4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    check("jge_cc000", 64'(e_Cnd), 64'h1);
    setE(4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    check("jg_cc000", 64'(e_Cnd), 64'h1);
    setE(4'h7, 4'h7, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    check("j7_cc000", 64'(e_Cnd), 64'h0);

    // stack and address arithmetic
    setE(4'hA, 4'h0, 64'h77, 64'h100, 64'h0, 4'h4, 4'hF);
    check("push_e_valE", e_valE, 64'hF8);
    setE(4'hB, 4'h0, 64'h77, 64'h100, 64'h0, 4'h4, 4'h5);
    check("pop_e_valE", e_valE, 64'h108);
    setE(4'h9, 4'h0, 64'h77, 64'h200, 64'h0, 4'h4, 4'hF);
    check("ret_e_valE", e_valE, 64'h208);
    setE(4'h3, 4'h0, 64'h77, 64'h999, 64'h1234, 4'h6, 4'hF);
    check("irmov_e_valE", e_valE, 64'h1234);
    setE(4'h5, 4'h0, 64'h77, 64'h20, 64'h10, 4'hF, 4'h7);
    check("mrmov_e_valE", e_valE, 64'h30);
    setE(4'hC, 4'h0, 64'h5, 64'h7, 64'h9, 4'h1, 4'hF);
    check("badicode_e_valE", e_valE, 64'h0);
    setE(4'h8, 4'h0, 64'h77, 64'h0, 64'h0, 4'h4, 4'hF);
    check("call_e_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    check("call_M_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFF8);
    check("call_M_icode", 64'(M_icode), 64'h8);
    check("call_cc", 64'(cc_out), 64'h0);

    // sub overflow: 0x8000.. - 1 -> 0x7FFF.., CC 001
    setE(4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 4'h1, 4'hF);
    check("subof_e_valE", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    tick();
    check("subof_cc", 64'(cc_out), 64'h1);
    setE(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    check("jl_cc001", 64'(e_Cnd), 64'h1);
    setE(4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    check("jge_cc001", 64'(e_Cnd), 64'h0);

    // reset mid-operation discards the in-flight OPq
    setE(4'h6, 4'h0, 64'h10, 64'h20, 64'h0, 4'h2, 4'h3);
    reset = 1'b1;
    tick();
    check("midrst_M_icode", 64'(M_icode), 64'h1);
    check("midrst_M_valE", M_valE, 64'h0);
    check("midrst_M_dstM", 64'(M_dstM), 64'hF);
    check("midrst_cc", 64'(cc_out), 64'h4);
    reset = 1'b0;
    setE(4'h6, 4'h1, 64'h3, 64'h5, 64'h0, 4'h2, 4'hF);
    tick();
    check("postrst_M_icode", 64'(M_icode), 64'h6);
    check("postrst_M_valE", M_valE, 64'h2);
    check("postrst_cc", 64'(cc_out), 64'h0);

    // bubble during OPq: M gets a nop, CC still updates
    setE(4'h6, 4'h1, 64'h1, 64'h1, 64'h0, 4'h2, 4'hF);
    M_bubble = 1'b1;
    #1;
    tick();
    check("bub_M_icode", 64'(M_icode), 64'h1);
    check("bub_M_valE", M_valE, 64'h0);
    check("bub_M_dstE", 64'(M_dstE), 64'hF);
    check("bub_M_Cnd", 64'(M_Cnd), 64'h0);
    check("bub_cc", 64'(cc_out), 64'h4);
    M_bubble = 1'b0;
    setE(4'h7, 4'h4, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
    check("jne_after_bub", 64'(e_Cnd), 64'h0);
    tick();
    check("jne_M_icode", 64'(M_icode), 64'h7);
    check("jne_M_Cnd", 64'(M_Cnd), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
